// File: rtl/lsu_mem_port_if.sv
// Memory-side request/acknowledge bus between the load/store unit and data memory.
interface lsu_mem_port_if;
  logic        m_req;
  logic        m_we;
  logic [9:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_be, m_wdata,
                  input  m_ack, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_be, m_wdata,
                  output m_ack, m_rdata);
endinterface

// File: rtl/lsu_mem_port.sv
// CPU-side load/store initiator: alignment/size check, lane steering,
// req/ack handshake with timeout, sign-extended load return.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [1:0]            fault,
  lsu_mem_port_if.master        mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic        cnt_last;
  logic [1:0]  req_fault;
  logic [3:0]  be_dec;
  logic [31:0] wd_dec;
  logic [1:0]  op_size;
  logic [1:0]  op_lo;
  logic [31:0] load_val;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  assign cnt_last  = (cnt == 16'(TIMEOUT - 1));
  assign mem.m_req = (state == S_BUSY);

  // Request decode: fault code, byte enables and lane-replicated write data.
  always_comb begin
    req_fault = 2'b00;
    be_dec    = '0;
    wd_dec    = '0;
    case (cpu_size)
      2'b00: begin
        be_dec = 4'b1111;
        wd_dec = cpu_wdata;
        if (cpu_addr[1:0] != 2'b00) req_fault = 2'b01;
      end
      2'b01: begin
        be_dec = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_dec = {2{cpu_wdata[15:0]}};
        if (cpu_addr[0]) req_fault = 2'b01;
      end
      2'b10: begin
        be_dec = 4'b0001 << cpu_addr[1:0];
        wd_dec = {4{cpu_wdata[7:0]}};
      end
      default: req_fault = 2'b10;
    endcase
  end

  // Load lane extraction and sign extension from the latched access shape.
  always_comb begin
    load_val = '0;
    half_v   = op_lo[1] ? mem.m_rdata[31:16] : mem.m_rdata[15:0];
    byte_v   = '0;
    case (op_lo)
      2'b00:   byte_v = mem.m_rdata[7:0];
      2'b01:   byte_v = mem.m_rdata[15:8];
      2'b10:   byte_v = mem.m_rdata[23:16];
      default: byte_v = mem.m_rdata[31:24];
    endcase
    case (op_size)
      2'b00:   load_val = mem.m_rdata;
      2'b01:   load_val = {{16{half_v[15]}}, half_v};
      2'b10:   load_val = {{24{byte_v[7]}}, byte_v};
      default: load_val = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        stall = cpu_req;
        if (cpu_req) state_next = (req_fault != 2'b00) ? S_ERR : S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mem.m_ack)     state_next = S_DONE;
        else if (cnt_last) state_next = S_ERR;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        err        = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Access latching, timeout counting, load capture and fault reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata       <= '0;
      fault       <= 2'b00;
      cnt         <= '0;
      mem.m_we    <= 1'b0;
      mem.m_addr  <= '0;
      mem.m_be    <= '0;
      mem.m_wdata <= '0;
      op_size     <= 2'b00;
      op_lo       <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            if (req_fault != 2'b00) begin
              fault <= req_fault;
            end else begin
              fault       <= 2'b00;
              cnt         <= '0;
              mem.m_we    <= cpu_we;
              mem.m_addr  <= cpu_addr[11:2];
              mem.m_be    <= be_dec;
              mem.m_wdata <= wd_dec;
              op_size     <= cpu_size;
              op_lo       <= cpu_addr[1:0];
            end
          end
        end
        S_BUSY: begin
          if (mem.m_ack) begin
            rdata <= mem.m_we ? 32'h0 : load_val;
            cnt   <= '0;
          end else if (cnt_last) begin
            fault <= 2'b11;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: stimulus queues expected responses,
// a monitor pops and checks them on each done/err pulse.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  fault;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err), .fault(fault),
    .mem(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [1:0]  fault;
    logic [31:0] rdata;
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int unsigned req_cyc;
    int unsigned stall_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] model_rdata = '0;

  int          ack_delay = -1;
  logic [31:0] mem_word  = '0;
  int          bcnt      = 0;
  logic        seen_we;
  logic [9:0]  seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay BUSY cycles and records the bus it saw.
  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req) begin
        if (bcnt == ack_delay) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_word;
          seen_we     = bus.m_we;
          seen_addr   = bus.m_addr;
          seen_be     = bus.m_be;
          seen_wdata  = bus.m_wdata;
          bcnt        = 0;
        end else begin
          bus.m_ack = 1'b0;
          bcnt++;
        end
      end else begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'hA5A5_A5A5;
        bcnt        = 0;
      end
    end
  end

  // Monitor: counts stall/m_req cycles per access and checks each completion.
  initial begin
    int unsigned sc = 0, rc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sc = 0; rc = 0;
      end else begin
        if (stall)      sc++;
        if (bus.m_req)  rc++;
        if (done || err) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_completion: done=%0b err=%0b with empty scoreboard", done, err);
          end else begin
            e = sb.pop_front();
            check("kind_err",  {31'd0, err},  {31'd0, e.is_err});
            check("fault",     {30'd0, fault}, {30'd0, e.fault});
            check("rdata",     rdata,          e.rdata);
            check("req_cycles",   rc, e.req_cyc);
            check("stall_cycles", sc, e.stall_cyc);
            if (!e.is_err) begin
              check("m_we",    {31'd0, seen_we},   {31'd0, e.we});
              check("m_addr",  {22'd0, seen_addr}, {22'd0, e.addr});
              check("m_be",    {28'd0, seen_be},   {28'd0, e.be});
              check("m_wdata", seen_wdata,         e.wdata);
            end
          end
          sc = 0; rc = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input logic [31:0] word,
                       input exp_t e);
    logic seen = 1'b0;
    ack_delay = dly;
    mem_word  = word;
    sb.push_back(e);
    cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    cpu_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL completion_timeout: got no done/err expected one within 40 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_ok(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input logic [31:0] word,
                       input logic [9:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd, input int unsigned ereq);
    exp_t e;
    e.is_err = 1'b0; e.fault = 2'b00; e.rdata = erd; e.we = we;
    e.addr = ea; e.be = ebe; e.wdata = ewd;
    e.req_cyc = ereq; e.stall_cyc = ereq + 1;
    model_rdata = erd;
    issue(we, size, addr, wdata, dly, word, e);
  endtask

  task automatic do_err(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input int dly, input logic [1:0] ef, input int unsigned ereq);
    exp_t e;
    e.is_err = 1'b1; e.fault = ef; e.rdata = model_rdata; e.we = 1'b0;
    e.addr = '0; e.be = '0; e.wdata = '0;
    e.req_cyc = ereq; e.stall_cyc = ereq + 1;
    issue(we, size, addr, 32'h1357_9BDF, dly, 32'hDEAD_0000, e);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall",  {31'd0, stall},     32'd0);
    check("rst_m_req",  {31'd0, bus.m_req}, 32'd0);
    check("rst_bus",    {bus.m_we, bus.m_addr, bus.m_be, 17'd0}, 32'd0);
    check("rst_wdata",  bus.m_wdata,        32'd0);
    check("rst_rdata",  rdata,              32'd0);
    check("rst_flags",  {28'd0, done, err, fault}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     we    size   addr          wdata         dly word          addr   be       wdata         rdata         req
    do_ok(1'b0, 2'b00, 32'h0000_0010, 32'h0,        0, 32'h8000_1234, 10'd4, 4'b1111, 32'h0,        32'h8000_1234, 1);
    do_ok(1'b0, 2'b10, 32'h0000_0023, 32'h0,        0, 32'h9A00_0000, 10'd8, 4'b1000, 32'h0,        32'hFFFF_FF9A, 1);
    do_ok(1'b0, 2'b01, 32'h0000_0022, 32'h0,        1, 32'h7FFF_0000, 10'd8, 4'b1100, 32'h0,        32'h0000_7FFF, 2);
    do_ok(1'b0, 2'b10, 32'h0000_0021, 32'h0,        0, 32'h0000_8000, 10'd8, 4'b0010, 32'h0,        32'hFFFF_FF80, 1);
    do_ok(1'b0, 2'b01, 32'h0000_0020, 32'h0,        0, 32'hFFFF_1234, 10'd8, 4'b0011, 32'h0,        32'h0000_1234, 1);
    do_ok(1'b1, 2'b01, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'h1234_5678, 10'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1);
    do_ok(1'b0, 2'b00, 32'h0000_0ffc, 32'h0,        0, 32'h0BAD_F00D, 10'h3FF, 4'b1111, 32'h0,      32'h0BAD_F00D, 1);
    do_ok(1'b1, 2'b10, 32'h0000_0001, 32'h0000_0055, 2, 32'h1234_5678, 10'd0, 4'b0010, 32'h5555_5555, 32'h0,        3);

    do_err(1'b0, 2'b00, 32'h0000_0002, 0,  2'b01, 0);
    do_err(1'b0, 2'b01, 32'h0000_0003, 0,  2'b01, 0);
    do_err(1'b1, 2'b11, 32'h0000_0001, 0,  2'b10, 0);
    do_err(1'b0, 2'b00, 32'h0000_0040, -1, 2'b11, 4);
    do_ok(1'b0, 2'b00, 32'h0000_0040, 32'h0,        3, 32'hCAFE_F00D, 10'h10, 4'b1111, 32'h0,       32'hCAFE_F00D, 4);

    // Reset in the second BUSY cycle aborts the access without done/err.
    ack_delay = -1;
    cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h0000_0080; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("abort_busy1_req", {31'd0, bus.m_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("abort_m_req", {31'd0, bus.m_req}, 32'd0);
    check("abort_stall", {31'd0, stall},     32'd0);
    check("abort_fault", {30'd0, fault},     32'd0);
    reset = 1'b0;
    model_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_ok(1'b0, 2'b00, 32'h0000_0010, 32'h0, 1, 32'h2468_ACE0, 10'd4, 4'b1111, 32'h0, 32'h2468_ACE0, 2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
